const_loader: RTL and testbench
===============================

// Module: const_loader
// PURPOSE
//  Sequencer downstream of the constant ROM (const_). On request it drives the ROM's one-hot
//  address, captures the registered 1188-bit GF(3^M) constant and its effective flag, and
//  writes the constant into the data RAM as CHUNK-bit words, LSB chunk first. Invalid
//  selections are reported, never written. Sits between the microcode controller and the RAM.
// PARAMETERS
//  WIDTH   1188  bits per GF(3^M) element (WIDTH_D0+1)
//  CHUNK   64    RAM word width
//  ADDR_W  10    RAM address width
//  NCH     19    chunks per element = ceil(WIDTH/CHUNK); derived, not overridden
// PORTS
//  clk        in   1      clock, all state changes on posedge
//  reset_n    in   1      asynchronous, active-low reset
//  req        in   1      start request, sampled only in IDLE
//  const_sel  in   3      0:zero 1:one 2:plus 3:minus 4:cubic; 5-7 invalid
//  dst        in   ADDR_W RAM base address, sampled with req
//  busy       out  1      high while state != IDLE
//  done       out  1      one-cycle completion pulse
//  err        out  1      one-cycle, coincident with done, if ROM reported effective=0
//  rom_addr   out  6      to const_ addr; one-hot 1<<const_sel, 0 for invalid sel
//  rom_out    in   WIDTH  from const_ out (valid one cycle after rom_addr)
//  rom_eff    in   1      from const_ effective
//  mem_we     out  1      RAM write enable
//  mem_addr   out  ADDR_W RAM write address
//  mem_wdata  out  CHUNK  RAM write data
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; busy, done, err, mem_we = 0; rom_addr, mem_addr,
//    mem_wdata, chunk counter, capture register = 0. A transfer in progress is abandoned and
//    not resumed.
//  - All outputs are registered (Moore). Cycle 0 = cycle in which req=1 is sampled in IDLE.
//  - FSM: IDLE -> FETCH -> CAPTURE -> WRITE (NCH cycles) -> DONE -> IDLE.
//    Invalid path: CAPTURE -> DONE.
//  - IDLE: on req, latch dst and rom_addr. State is FETCH in cycle 1.
//  - FETCH (cycle 1): hold rom_addr; const_ registers its output at the end of this cycle.
//  - CAPTURE (cycle 2): if rom_eff=1, load rom_out into the capture register, zero-pad to
//    NCH*CHUNK bits, go to WRITE. Otherwise go to DONE with err.
//  - WRITE (cycles 3..NCH+2): mem_we=1. In write k (k=0..NCH-1), mem_addr = dst+k mod 2^ADDR_W
//    and mem_wdata = bits [CHUNK*k+CHUNK-1 : CHUNK*k]. The last chunk's upper
//    NCH*CHUNK-WIDTH bits (28) are 0.
//  - DONE: done=1 for one cycle, then IDLE. Valid path: done in cycle NCH+3 = 22.
//    Invalid path: done and err in cycle 3, no mem_we.
//  - busy=1 from cycle 1 through the done cycle inclusive. req is ignored while busy;
//    no queueing. A new req in the cycle after done is accepted.
//  - rom_addr returns to 0 in every state except FETCH and CAPTURE.
//  - mem_addr and mem_wdata hold their last values when mem_we=0.
// TESTING
//  1. sel=1, dst=0x010 -> mem_we high cycles 3..21, addrs 0x010..0x022;
//     chunk0=0x1, chunks1-18=0; done cycle 22, err=0.
//  2. sel=2 (plus) -> chunks0-17=0, chunk18=0x1_4000_0000;
//     sel=4 (cubic) -> chunk18=0x5_4000_0000.
//  3. sel=6 -> rom_addr=0, rom_eff=0, no mem_we, done=err=1 in cycle 3, busy low cycle 4.
//  4. dst=0x3F0 -> addrs 0x3F0..0x3FF then wrap to 0x000..0x002.
//  5. req held high through a whole transfer -> exactly one transfer per IDLE visit;
//     second transfer starts the cycle after done.
//  6. reset_n pulsed low during write k=5 -> all outputs 0 immediately; after release IDLE,
//     no further writes until a new req.

Source files
------------

// File: rtl/const_loader_if.sv
// Bus bundle between the microcode controller / constant ROM (master side)
// and the constant loader (slave side).
interface const_loader_if #(
    parameter int WIDTH  = 1188,
    parameter int CHUNK  = 64,
    parameter int ADDR_W = 10
);
    logic              req;
    logic [2:0]        const_sel;
    logic [ADDR_W-1:0] dst;
    logic              busy;
    logic              done;
    logic              err;
    logic [5:0]        rom_addr;
    logic [WIDTH-1:0]  rom_out;
    logic              rom_eff;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [CHUNK-1:0]  mem_wdata;

    modport master (
        output req, const_sel, dst, rom_out, rom_eff,
        input  busy, done, err, rom_addr, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req, const_sel, dst, rom_out, rom_eff,
        output busy, done, err, rom_addr, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/const_loader.sv
// Fetches one GF(3^M) constant from the constant ROM and streams it into the
// data RAM as CHUNK-bit words, least significant chunk first.
module const_loader #(
    parameter int WIDTH  = 1188,
    parameter int CHUNK  = 64,
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    const_loader_if.slave bus
);
    localparam int NCH   = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PADW  = NCH * CHUNK;
    localparam int CNT_W = $clog2(NCH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [5:0]        rom_addr_q, rom_addr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [CHUNK-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PADW-1:0]   cap_q, cap_d;
    logic [PADW-1:0]   padded;

    // NOTE: every _d gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        we_d       = 1'b0;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        padded             = '0;
        padded[WIDTH-1:0]  = bus.rom_out;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_d    = S_FETCH;
                    dst_d      = bus.dst;
                    rom_addr_d = (bus.const_sel <= 3'd4) ? (6'b1 << bus.const_sel) : 6'b0;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rom_addr_d = 6'b0;
                // A zero ROM address means the selection was invalid; never write it.
                if (bus.rom_eff && (rom_addr_q != 6'b0)) begin
                    state_d = S_WRITE;
                    cap_d   = padded >> CHUNK;
                    wdata_d = padded[CHUNK-1:0];
                    maddr_d = dst_q;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                if (cnt_q == CNT_W'(NCH - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    maddr_d = maddr_q + ADDR_W'(1);
                    wdata_d = cap_q[CHUNK-1:0];
                    cap_d   = cap_q >> CHUNK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: the capture register is an ordinary flop bank, not a RAM, so it is reset like the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rom_addr_q <= '0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            cap_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rom_addr_q <= rom_addr_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_const_loader.sv
// Scoreboard bench for const_loader: directed requests push expected RAM writes
// and completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_const_loader;
    localparam int WIDTH  = 1188;
    localparam int CHUNK  = 64;
    localparam int ADDR_W = 10;
    localparam int NCH    = 19;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [CHUNK-1:0]  data;
    } wr_t;

    typedef struct {
        int   cyc;
        logic err;
    } dn_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    wr_t  wq[$];
    dn_t  dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    const_loader_if #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ADDR_W(ADDR_W)) bus ();

    const_loader #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural constant ROM: one-hot address, output registered one cycle later.
    function automatic logic [WIDTH-1:0] rom_val(input logic [5:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        case (a)
            6'b000010: v[0] = 1'b1;
            6'b000100: begin v[1182] = 1'b1; v[1184] = 1'b1; end
            6'b001000: begin v[1183] = 1'b1; v[1185] = 1'b1; end
            6'b010000: begin v[1182] = 1'b1; v[1184] = 1'b1; v[1186] = 1'b1; end
            default: ;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        bus.rom_out <= rom_val(bus.rom_addr);
        bus.rom_eff <= (bus.rom_addr inside {6'd1, 6'd2, 6'd4, 6'd8, 6'd16});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mem_we) begin
                if (wq.size() == 0) begin
                    check("spurious_write", bus.mem_we, 1'b0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_wdata, e.data);
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    check("spurious_done", bus.done, 1'b0);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_err", bus.err, d.err);
                end
            end else if (bus.err) begin
                check("err_without_done", bus.err, 1'b0);
            end
        end
    end

    task automatic push_expect(input int c, input logic [ADDR_W-1:0] dst,
                               input logic [63:0] c0, input logic [63:0] c18,
                               input logic exp_err, input int nwr, input bit with_done);
        for (int k = 0; k < nwr; k++) begin
            wr_t w;
            w.cyc  = c + 3 + k;
            w.addr = dst + ADDR_W'(k);
            w.data = (k == 0) ? c0 : ((k == NCH - 1) ? c18 : 64'h0);
            wq.push_back(w);
        end
        if (with_done) begin
            dn_t d;
            d.cyc = exp_err ? c + 3 : c + NCH + 3;
            d.err = exp_err;
            dq.push_back(d);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy) check("idle_timeout", bus.busy, 1'b0);
    endtask

    // Returns one cycle after the request was sampled (cycle 1 of the transfer).
    task automatic issue(input logic [2:0] sel, input logic [ADDR_W-1:0] dst,
                         input logic [5:0] exp_ra, input logic [63:0] c0,
                         input logic [63:0] c18, input logic exp_err,
                         input int nwr, input bit with_done, input bit hold,
                         output int c);
        wait_idle();
        bus.req       = 1'b1;
        bus.const_sel = sel;
        bus.dst       = dst;
        c = cyc;
        push_expect(c, dst, c0, c18, exp_err, nwr, with_done);
        @(posedge clk); #1;
        check("rom_addr_fetch", bus.rom_addr, exp_ra);
        check("busy_cycle1", bus.busy, 1'b1);
        if (!hold) bus.req = 1'b0;
    endtask

    initial begin
        int c;
        bus.req       = 1'b0;
        bus.const_sel = 3'd0;
        bus.dst       = '0;
        reset_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_rom_addr", bus.rom_addr, 6'b0);
        check("rst_mem_addr", bus.mem_addr, 10'h0);
        check("rst_mem_wdata", bus.mem_wdata, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Each valid constant: chunk 0 and chunk 18 hand-computed, rest zero.
        issue(3'd1, 10'h010, 6'b000010, 64'h1, 64'h0, 1'b0, NCH, 1'b1, 1'b0, c);
        issue(3'd2, 10'h040, 6'b000100, 64'h0, 64'h1_4000_0000, 1'b0, NCH, 1'b1, 1'b0, c);
        issue(3'd4, 10'h080, 6'b010000, 64'h0, 64'h5_4000_0000, 1'b0, NCH, 1'b1, 1'b0, c);
        issue(3'd0, 10'h0C0, 6'b000001, 64'h0, 64'h0, 1'b0, NCH, 1'b1, 1'b0, c);
        issue(3'd3, 10'h100, 6'b001000, 64'h0, 64'h2_8000_0000, 1'b0, NCH, 1'b1, 1'b0, c);

        // Invalid selections: error completion in cycle 3, idle in cycle 4.
        issue(3'd6, 10'h200, 6'b000000, 64'h0, 64'h0, 1'b1, 0, 1'b1, 1'b0, c);
        repeat (3) @(posedge clk);
        #1;
        check("invalid_busy_cycle4", bus.busy, 1'b0);
        issue(3'd5, 10'h210, 6'b000000, 64'h0, 64'h0, 1'b1, 0, 1'b1, 1'b0, c);
        issue(3'd7, 10'h220, 6'b000000, 64'h0, 64'h0, 1'b1, 0, 1'b1, 1'b0, c);

        // Address wrap at the top of the RAM.
        issue(3'd1, 10'h3F0, 6'b000010, 64'h1, 64'h0, 1'b0, NCH, 1'b1, 1'b0, c);

        // req held high: the second transfer starts the cycle after done.
        issue(3'd1, 10'h050, 6'b000010, 64'h1, 64'h0, 1'b0, NCH, 1'b1, 1'b1, c);
        push_expect(c + NCH + 4, 10'h050, 64'h1, 64'h0, 1'b0, NCH, 1'b1);
        repeat (NCH + 4) @(posedge clk);
        #1;
        check("hold_second_fetch", bus.rom_addr, 6'b000010);
        check("hold_second_busy", bus.busy, 1'b1);
        bus.req = 1'b0;

        // Reset during write k=5: only k=0..4 may appear, nothing afterwards.
        issue(3'd1, 10'h300, 6'b000010, 64'h1, 64'h0, 1'b0, 5, 1'b0, 1'b0, c);
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_mem_we", bus.mem_we, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_done", bus.done, 1'b0);
        check("midrst_err", bus.err, 1'b0);
        check("midrst_rom_addr", bus.rom_addr, 6'b0);
        check("midrst_mem_addr", bus.mem_addr, 10'h0);
        check("midrst_mem_wdata", bus.mem_wdata, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_busy", bus.busy, 1'b0);
        check("postrst_mem_we", bus.mem_we, 1'b0);

        issue(3'd2, 10'h020, 6'b000100, 64'h0, 64'h1_4000_0000, 1'b0, NCH, 1'b1, 1'b0, c);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("writes_drained", wq.size(), 0);
        check("dones_drained", dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end
endmodule
